// File: rtl/prim_pipe_elastic_pkg.sv
// Shared helpers for the elastic pipeline register.
//   cnt_width(depth) : bit width needed to hold an occupancy count of 0..depth.
package prim_pipe_elastic_pkg;

  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prim_pipe_slot.sv
// One stage of the elastic pipeline: a valid bit plus a DW-bit data register.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (valid=0, data=DEFAULT)
//   flush_i  clear the valid bit, keep the data
//   vld_i    valid of the upstream slot (or the block input)
//   data_i   data of the upstream slot (or the block input)
//   rdy_i    ready of the downstream slot (or out_ready_i for the last slot)
//   vld_o    valid bit held in this slot
//   data_o   data held in this slot
//   rdy_o    this slot can take a new beat: empty, or its beat moves on
module prim_pipe_slot
  import prim_pipe_elastic_pkg::*;
#(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   DEFAULT = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          vld_i,
  input  logic [DW-1:0] data_i,
  input  logic          rdy_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o,
  output logic          rdy_o
);

  logic          vld_p0;
  logic [DW-1:0] data_p0;

  assign rdy_o  = ~vld_p0 | rdy_i;
  assign vld_o  = vld_p0;
  assign data_o = data_p0;

  // stage register: an empty incoming slot only clears valid, data is kept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0  <= 1'b0;
      data_p0 <= DEFAULT;
    end else if (flush_i) begin
      vld_p0  <= 1'b0;
    end else if (rdy_o) begin
      vld_p0 <= vld_i;
      if (vld_i) begin
        data_p0 <= data_i;
      end
    end
  end

endmodule

// File: rtl/prim_pipe_elastic.sv
// Elastic pipeline register: DEPTH valid/data slots with valid/ready handshakes.
// Ready propagates combinationally from the output back to the input, so empty
// slots (bubbles) are always filled even while the output is stalled.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   flush_i      discard every slot this cycle; no beat accepted
//   in_valid_i   upstream offers in_data_i
//   in_ready_o   block accepts in_data_i this cycle
//   in_data_i    upstream data
//   out_valid_o  last slot holds valid data
//   out_ready_i  downstream accepts out_data_o
//   out_data_o   data register of the last slot
//   count_o      number of valid slots, 0..DEPTH
module prim_pipe_elastic
  import prim_pipe_elastic_pkg::*;
#(
  parameter int            DW      = 32,
  parameter int            DEPTH   = 1,
  parameter logic [DW-1:0] DEFAULT = '0,
  localparam int           CW      = cnt_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [CW-1:0] count_o
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("prim_pipe_elastic: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] vld_vec;
  logic             in_fire;
  logic             out_fire;

  // Each slot keeps its own ready net; chaining through separate per-stage
  // signals keeps the ready path a plain acyclic chain.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          vld_s;
    logic [DW-1:0] data_s;
    logic          rdy_s;
    logic          vld_up;
    logic [DW-1:0] data_up;
    logic          rdy_dn;

    if (k == 0) begin : g_head
      assign vld_up  = in_valid_i;
      assign data_up = in_data_i;
    end else begin : g_body
      assign vld_up  = g_stage[k-1].vld_s;
      assign data_up = g_stage[k-1].data_s;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign rdy_dn = out_ready_i;
    end else begin : g_mid
      assign rdy_dn = g_stage[k+1].rdy_s;
    end

    prim_pipe_slot #(
      .DW      (DW),
      .DEFAULT (DEFAULT)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .vld_i   (vld_up),
      .data_i  (data_up),
      .rdy_i   (rdy_dn),
      .vld_o   (vld_s),
      .data_o  (data_s),
      .rdy_o   (rdy_s)
    );

    assign vld_vec[k] = vld_s;
  end

  assign in_ready_o  = g_stage[0].rdy_s & ~flush_i;
  assign out_valid_o = g_stage[DEPTH-1].vld_s;
  assign out_data_o  = g_stage[DEPTH-1].data_s;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // occupancy register: tracks handshakes, cleared by flush and reset
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count_o <= '0;
    end else if (in_fire && !out_fire) begin
      count_o <= count_o + CW'(1);
    end else if (out_fire && !in_fire) begin
      count_o <= count_o - CW'(1);
    end
  end

`ifndef SYNTHESIS
  logic          stall_q;
  logic [DW-1:0] held_q;

  always_ff @(posedge clk_i) begin
    stall_q <= ~rst_i & in_valid_i & ~in_ready_o & ~flush_i;
    held_q  <= in_data_i;
    if (!rst_i) begin
      assert (count_o == CW'($countones(vld_vec)))
        else $error("prim_pipe_elastic: count_o %0d disagrees with valid slots %b", count_o, vld_vec);
      if (stall_q && in_valid_i && !flush_i) begin
        assert (in_data_i == held_q)
          else $error("prim_pipe_elastic: in_data_i changed while stalled");
      end
    end
  end
`endif

endmodule
